// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU and its iterative multiply/divide engine:
// op codes, sequencer state encoding and the iteration counter width helper.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_GTU   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_MULT  = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;
    localparam logic [3:0] ALU_DIV   = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MFHI  = 4'b1101;
    localparam logic [3:0] ALU_MFLO  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // Counter only has to reach WIDTH-1 iterations.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per cycle
// over operand magnitudes, followed by a single sign-correction (FIX) cycle.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int unsigned CW = cnt_width(WIDTH);

    md_state_t        state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_hi, r_lo, op_mag, dividend;
    logic             is_div, is_signed, sign_a, sign_b, b_zero;

    logic             start_div, start_signed;
    logic [WIDTH-1:0] mag_1, mag_2;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot, rem;

    assign start_div    = (op == ALU_DIVU) || (op == ALU_DIV);
    assign start_signed = (op == ALU_MULT) || (op == ALU_DIV);
    assign mag_1 = (start_signed && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
    assign mag_2 = (start_signed && operand_2[WIDTH-1]) ? -operand_2 : operand_2;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIX);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_BUSY;
            ST_BUSY: if (cnt == CW'(WIDTH - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // r_hi:r_lo is the product accumulator (multiply) or remainder:quotient (divide)
    assign mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, op_mag} : '0);
    assign div_shift = {r_hi, r_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, op_mag};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            op_mag    <= '0;
            dividend  <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            b_zero    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        r_hi      <= '0;
                        r_lo      <= start_div ? mag_1 : mag_2;
                        op_mag    <= start_div ? mag_2 : mag_1;
                        dividend  <= operand_1;
                        is_div    <= start_div;
                        is_signed <= start_signed;
                        sign_a    <= operand_1[WIDTH-1];
                        sign_b    <= operand_2[WIDTH-1];
                        b_zero    <= (operand_2 == '0);
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        if (!div_trial[WIDTH]) begin
                            r_hi <= div_trial[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hi <= div_shift[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= mul_sum[WIDTH:1];
                        r_lo <= {mul_sum[0], r_lo[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Most-negative / -1 needs no special case: the wrapped negation yields it.
    always_comb begin
        prod = {r_hi, r_lo};
        quot = r_lo;
        rem  = r_hi;
        if (is_signed && (sign_a ^ sign_b)) begin
            prod = -prod;
            quot = -quot;
        end
        if (is_signed && sign_a) rem = -rem;

        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_hi = rem;
            res_lo = quot;
            if (b_zero) begin
                res_hi = dividend;
                res_lo = '1;
            end
        end
    end

endmodule

// File: rtl/alu_md_unit.sv
// Registered EX-stage ALU with valid/ready handshake, architectural HI/LO registers
// and an attached iterative multiply/divide engine that stalls acceptance while busy.
module alu_md_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             accept, is_md, md_start, md_busy, md_done;
    logic [WIDTH-1:0] md_hi, md_lo, alu_res, sum, diff;
    logic             alu_ovf;

    assign is_md = (alu_op == ALU_MULTU) || (alu_op == ALU_MULT) ||
                   (alu_op == ALU_DIVU)  || (alu_op == ALU_DIV);
    assign in_ready = !md_busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && is_md;

    muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .start     (md_start),
        .op        (alu_op),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .busy      (md_busy),
        .done      (md_done),
        .res_hi    (md_hi),
        .res_lo    (md_lo)
    );

    always_comb begin
        sum     = operand_1 + operand_2;
        diff    = operand_1 - operand_2;
        alu_res = sum;
        alu_ovf = 1'b0;
        case (alu_op)
            ALU_AND:  alu_res = operand_1 & operand_2;
            ALU_OR:   alu_res = operand_1 | operand_2;
            ALU_XOR:  alu_res = operand_1 ^ operand_2;
            ALU_NOR:  alu_res = ~(operand_1 | operand_2);
            ALU_GTU:  alu_res = {{(WIDTH-1){1'b0}}, (operand_1 > operand_2)};
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_1) < $signed(operand_2))};
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (operand_1[WIDTH-1] != operand_2[WIDTH-1]) &&
                          (diff[WIDTH-1] != operand_1[WIDTH-1]);
            end
            default: begin
                alu_res = sum;
                alu_ovf = (operand_1[WIDTH-1] == operand_2[WIDTH-1]) &&
                          (sum[WIDTH-1] != operand_1[WIDTH-1]);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (md_done) begin
            hi        <= md_hi;
            lo        <= md_lo;
            out       <= md_lo;
            zero      <= (md_lo == '0);
            overflow  <= 1'b0;
            out_valid <= 1'b1;
        end else if (accept && !is_md) begin
            out       <= alu_res;
            zero      <= (alu_res == '0);
            overflow  <= alu_ovf;
            out_valid <= 1'b1;
        end else if (md_start || (out_valid && out_ready)) begin
            out_valid <= 1'b0;
        end
    end

endmodule
